// File: rtl/gemm_w_pingpong_buff_if.sv
// rtl/gemm_w_pingpong_buff_if.sv - weight load, swap and read-stream bundle for the ping-pong weight buffer
//
// Purpose: groups the shadow-load handshake, bank-swap request and active-bank
// read stream of gemm_w_pingpong_buff into one bundle.
// Signals:
//   i_wr_valid / o_wr_ready / i_wr_data / i_wr_last : shadow bank load port
//   i_swap                                          : promote full shadow to active
//   i_rd_en / o_rd_data / o_rd_valid / o_rd_wrap    : active bank read stream
//   o_shadow_full / o_active_len                    : status
// Modports: master drives the inputs (compute controller), slave is the buffer.
interface gemm_w_pingpong_buff_if #(
    parameter int DATA_WIDTH = 16,
    parameter int COLS       = 2,
    parameter int DEPTH      = 512,
    parameter int N_DEPTH    = $clog2(DEPTH)
);
    logic                         i_wr_valid;
    logic                         o_wr_ready;
    logic [COLS*DATA_WIDTH-1:0]   i_wr_data;
    logic                         i_wr_last;
    logic                         i_swap;
    logic                         i_rd_en;
    logic [COLS*DATA_WIDTH-1:0]   o_rd_data;
    logic                         o_rd_valid;
    logic                         o_rd_wrap;
    logic                         o_shadow_full;
    logic [N_DEPTH:0]             o_active_len;

    modport master (
        output i_wr_valid, i_wr_data, i_wr_last, i_swap, i_rd_en,
        input  o_wr_ready, o_rd_data, o_rd_valid, o_rd_wrap, o_shadow_full, o_active_len
    );

    modport slave (
        input  i_wr_valid, i_wr_data, i_wr_last, i_swap, i_rd_en,
        output o_wr_ready, o_rd_data, o_rd_valid, o_rd_wrap, o_shadow_full, o_active_len
    );
endinterface

// File: rtl/gemm_w_pingpong_buff.sv
// rtl/gemm_w_pingpong_buff.sv - double-buffered weight store for one GEMM PE column group
//
// Purpose: the active bank streams weights to the PEs, wrapping at the length
// of its load, while the shadow bank is filled through a valid/ready port.
// A swap promotes a completely loaded shadow bank to active.
// Ports:
//   i_clk : clock
//   i_rst : asynchronous active-high reset
//   bus   : gemm_w_pingpong_buff_if.slave (load port, swap, read stream, status)
module gemm_w_pingpong_buff #(
    parameter int DATA_WIDTH = 16,
    parameter int COLS       = 2,
    parameter int DEPTH      = 512,
    parameter int N_DEPTH    = $clog2(DEPTH)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    gemm_w_pingpong_buff_if.slave         bus
);
    localparam int                 W        = COLS * DATA_WIDTH;
    localparam logic [N_DEPTH-1:0] PTR_ONE  = N_DEPTH'(1);
    localparam logic [N_DEPTH-1:0] PTR_LAST = N_DEPTH'(DEPTH - 1);
    localparam logic [N_DEPTH:0]   LEN_ONE  = (N_DEPTH + 1)'(1);

    typedef enum logic {LOADING, FULL} state_t;

    state_t               state;
    logic                 bank_sel;
    logic [N_DEPTH-1:0]   wptr;
    logic [N_DEPTH-1:0]   rptr;
    logic [N_DEPTH:0]     shadow_len;

    logic [W-1:0]         mem [0:1][0:DEPTH-1];

    logic                 wr_fire;
    logic                 swap_fire;
    logic                 rd_step;
    logic                 rd_at_end;
    logic                 bank_nxt;
    logic [N_DEPTH-1:0]   rptr_nxt;
    logic                 valid_nxt;

    assign wr_fire   = bus.i_wr_valid & bus.o_wr_ready;
    assign swap_fire = bus.i_swap & bus.o_shadow_full;
    // A swap in the same cycle as a read wins: the pointer restarts on the new bank.
    assign rd_step   = bus.i_rd_en & bus.o_rd_valid & ~swap_fire;
    assign rd_at_end = ({1'b0, rptr} == (bus.o_active_len - LEN_ONE));

    // Next-cycle bank/pointer drive the read register, so o_rd_data always
    // matches active[rptr] in the cycle it is presented.
    always_comb begin
        bank_nxt  = bank_sel;
        rptr_nxt  = rptr;
        valid_nxt = bus.o_rd_valid;
        if (swap_fire) begin
            bank_nxt  = ~bank_sel;
            rptr_nxt  = '0;
            valid_nxt = 1'b1;
        end else if (rd_step) begin
            rptr_nxt = rd_at_end ? '0 : rptr + PTR_ONE;
        end
    end

    // Weight storage is not reset; only the shadow bank is ever written.
    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem[~bank_sel][wptr] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= LOADING;
            bank_sel          <= 1'b0;
            wptr              <= '0;
            rptr              <= '0;
            shadow_len        <= '0;
            bus.o_active_len  <= '0;
            bus.o_shadow_full <= 1'b0;
            bus.o_wr_ready    <= 1'b1;
            bus.o_rd_valid    <= 1'b0;
            bus.o_rd_data     <= '0;
            bus.o_rd_wrap     <= 1'b0;
        end else begin
            bank_sel       <= bank_nxt;
            rptr           <= rptr_nxt;
            bus.o_rd_valid <= valid_nxt;
            bus.o_rd_data  <= valid_nxt ? mem[bank_nxt][rptr_nxt] : '0;
            bus.o_rd_wrap  <= rd_step & rd_at_end;

            if (swap_fire) begin
                bus.o_active_len <= shadow_len;
            end

            case (state)
                LOADING: begin
                    if (wr_fire) begin
                        wptr <= wptr + PTR_ONE;
                        // Load ends on an explicit last or when the bank is exhausted.
                        if (bus.i_wr_last || (wptr == PTR_LAST)) begin
                            state             <= FULL;
                            bus.o_wr_ready    <= 1'b0;
                            bus.o_shadow_full <= 1'b1;
                            shadow_len        <= {1'b0, wptr} + LEN_ONE;
                        end
                    end
                end
                FULL: begin
                    if (swap_fire) begin
                        state             <= LOADING;
                        wptr              <= '0;
                        bus.o_wr_ready    <= 1'b1;
                        bus.o_shadow_full <= 1'b0;
                    end
                end
                default: state <= LOADING;
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_w_pingpong_buff.sv
// tb/tb_gemm_w_pingpong_buff.sv - directed self-checking bench for gemm_w_pingpong_buff
module tb_gemm_w_pingpong_buff;
    localparam int DW    = 16;
    localparam int COLS  = 2;
    localparam int DEPTH = 512;
    localparam int N     = $clog2(DEPTH);
    localparam int W     = DW * COLS;

    logic clk;
    logic rst;

    int n_checks;
    int n_err;

    logic [W-1:0] seq4 [0:3];

    gemm_w_pingpong_buff_if #(.DATA_WIDTH(DW), .COLS(COLS), .DEPTH(DEPTH), .N_DEPTH(N)) bus ();

    gemm_w_pingpong_buff #(.DATA_WIDTH(DW), .COLS(COLS), .DEPTH(DEPTH), .N_DEPTH(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [W-1:0] d, input logic last);
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = d;
        bus.i_wr_last  = last;
        step();
        bus.i_wr_valid = 1'b0;
        bus.i_wr_last  = 1'b0;
    endtask

    task automatic do_swap();
        bus.i_swap = 1'b1;
        step();
        bus.i_swap = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_wr_last  = 1'b0;
        bus.i_swap     = 1'b0;
        bus.i_rd_en    = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_wr_ready", 64'(bus.o_wr_ready), 64'd1);
        chk("rst_rd_valid", 64'(bus.o_rd_valid), 64'd0);
        chk("rst_full", 64'(bus.o_shadow_full), 64'd0);
        chk("rst_rd_data", 64'(bus.o_rd_data), 64'd0);
        chk("rst_len", 64'(bus.o_active_len), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_rd_data_idle", 64'(bus.o_rd_data), 64'd0);

        // Basic load of 4, swap, stream with wrap.
        seq4[0] = 32'h0011_0001;
        seq4[1] = 32'h0022_0002;
        seq4[2] = 32'h0033_0003;
        seq4[3] = 32'h0044_0004;
        for (int i = 0; i < 4; i++) wr(seq4[i], i == 3);
        chk("load4_full", 64'(bus.o_shadow_full), 64'd1);
        chk("load4_ready", 64'(bus.o_wr_ready), 64'd0);
        do_swap();
        chk("swap4_valid", 64'(bus.o_rd_valid), 64'd1);
        chk("swap4_len", 64'(bus.o_active_len), 64'd4);
        chk("swap4_data", 64'(bus.o_rd_data), 64'h0011_0001);
        chk("swap4_full_clr", 64'(bus.o_shadow_full), 64'd0);
        bus.i_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rd4_data", 64'(bus.o_rd_data), 64'(seq4[(i + 1) % 4]));
            chk("rd4_wrap", 64'(bus.o_rd_wrap), 64'(i == 3));
        end
        bus.i_rd_en = 1'b0;
        step();
        chk("rd4_wrap_end", 64'(bus.o_rd_wrap), 64'd0);
        chk("rd4_hold", 64'(bus.o_rd_data), 64'h0011_0001);

        // Swap while shadow only partly loaded is ignored.
        wr(32'h0000_0100, 1'b0);
        wr(32'h0000_0101, 1'b0);
        do_swap();
        chk("early_swap_len", 64'(bus.o_active_len), 64'd4);
        chk("early_swap_data", 64'(bus.o_rd_data), 64'h0011_0001);
        chk("early_swap_full", 64'(bus.o_shadow_full), 64'd0);
        chk("early_swap_ready", 64'(bus.o_wr_ready), 64'd1);
        wr(32'h0000_0102, 1'b1);
        chk("load3_full", 64'(bus.o_shadow_full), 64'd1);
        do_swap();
        chk("swap3_len", 64'(bus.o_active_len), 64'd3);
        chk("swap3_data", 64'(bus.o_rd_data), 64'h0000_0100);

        // Fill a whole bank without last; extra write must be dropped.
        for (int i = 0; i < DEPTH; i++) begin
            wr(32'h5000_0000 + W'(i), 1'b0);
            if (i == DEPTH - 2) chk("fill_not_full", 64'(bus.o_shadow_full), 64'd0);
        end
        chk("fill_full", 64'(bus.o_shadow_full), 64'd1);
        chk("fill_ready", 64'(bus.o_wr_ready), 64'd0);
        wr(32'hDEAD_BEEF, 1'b0);
        chk("drop_full", 64'(bus.o_shadow_full), 64'd1);
        do_swap();
        chk("fill_len", 64'(bus.o_active_len), 64'(DEPTH));
        chk("fill_first", 64'(bus.o_rd_data), 64'h5000_0000);
        bus.i_rd_en = 1'b1;
        repeat (DEPTH - 1) step();
        chk("fill_last", 64'(bus.o_rd_data), 64'h5000_01FF);
        chk("fill_last_nowrap", 64'(bus.o_rd_wrap), 64'd0);
        step();
        chk("fill_wrap_data", 64'(bus.o_rd_data), 64'h5000_0000);
        chk("fill_wrap", 64'(bus.o_rd_wrap), 64'd1);
        bus.i_rd_en = 1'b0;

        // Stream len 4 while loading len 3, then swap + read together.
        seq4[0] = 32'h0000_0061;
        seq4[1] = 32'h0000_0062;
        seq4[2] = 32'h0000_0063;
        seq4[3] = 32'h0000_0064;
        for (int i = 0; i < 4; i++) wr(seq4[i], i == 3);
        do_swap();
        chk("s4_first", 64'(bus.o_rd_data), 64'h61);
        for (int k = 0; k < 3; k++) begin
            bus.i_rd_en    = 1'b1;
            bus.i_wr_valid = 1'b1;
            bus.i_wr_data  = 32'h0000_000A + W'(k);
            bus.i_wr_last  = (k == 2);
            step();
            chk("stream_rd", 64'(bus.o_rd_data), 64'(seq4[k + 1]));
        end
        bus.i_wr_valid = 1'b0;
        bus.i_wr_last  = 1'b0;
        chk("stream_full", 64'(bus.o_shadow_full), 64'd1);
        bus.i_swap = 1'b1;
        step();
        bus.i_swap = 1'b0;
        chk("swaprd_data", 64'(bus.o_rd_data), 64'hA);
        chk("swaprd_len", 64'(bus.o_active_len), 64'd3);
        chk("swaprd_nowrap", 64'(bus.o_rd_wrap), 64'd0);
        step();
        chk("s3_b", 64'(bus.o_rd_data), 64'hB);
        step();
        chk("s3_c", 64'(bus.o_rd_data), 64'hC);
        chk("s3_c_nowrap", 64'(bus.o_rd_wrap), 64'd0);
        step();
        chk("s3_a", 64'(bus.o_rd_data), 64'hA);
        chk("s3_wrap", 64'(bus.o_rd_wrap), 64'd1);
        bus.i_rd_en = 1'b0;

        // Length 1: every read wraps.
        wr(32'h0000_0077, 1'b1);
        do_swap();
        chk("len1_len", 64'(bus.o_active_len), 64'd1);
        chk("len1_data", 64'(bus.o_rd_data), 64'h77);
        bus.i_rd_en = 1'b1;
        step();
        chk("len1_wrap_a", 64'(bus.o_rd_wrap), 64'd1);
        chk("len1_data_a", 64'(bus.o_rd_data), 64'h77);
        step();
        chk("len1_wrap_b", 64'(bus.o_rd_wrap), 64'd1);

        // Asynchronous reset mid-load, then a fresh 2-word load.
        wr(32'h0000_0099, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_wrap", 64'(bus.o_rd_wrap), 64'd0);
        chk("arst_valid", 64'(bus.o_rd_valid), 64'd0);
        chk("arst_data", 64'(bus.o_rd_data), 64'd0);
        chk("arst_len", 64'(bus.o_active_len), 64'd0);
        chk("arst_ready", 64'(bus.o_wr_ready), 64'd1);
        chk("arst_full", 64'(bus.o_shadow_full), 64'd0);
        bus.i_rd_en = 1'b0;
        step();
        rst = 1'b0;
        step();
        wr(32'h0000_0021, 1'b0);
        wr(32'h0000_0022, 1'b1);
        do_swap();
        chk("post_rst_len", 64'(bus.o_active_len), 64'd2);
        chk("post_rst_data0", 64'(bus.o_rd_data), 64'h21);
        bus.i_rd_en = 1'b1;
        step();
        chk("post_rst_data1", 64'(bus.o_rd_data), 64'h22);
        step();
        chk("post_rst_wrap_data", 64'(bus.o_rd_data), 64'h21);
        chk("post_rst_wrap", 64'(bus.o_rd_wrap), 64'd1);
        bus.i_rd_en = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
